// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, constants and round-robin search for the bus master arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, GRANT, TURN} arb_state_e;

    localparam int OwnerWidth = 3;

    // Returns the first requester after ptr (indices 1..n-1, bit idx-1 of req), or 0 if none.
    // Scanning downward lets the nearest candidate overwrite the farther ones.
    function automatic logic [OwnerWidth-1:0] rr_next(
        input logic [6:0]            req,
        input logic [OwnerWidth-1:0] ptr,
        input int                    n
    );
        logic [OwnerWidth-1:0] win;
        int idx;
        win = '0;
        for (int k = 7; k >= 1; k--) begin
            if (k < n) begin
                idx = (int'(ptr) - 1 + k) % (n - 1) + 1;
                if (|(req & (7'd1 << (idx - 1)))) win = OwnerWidth'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_select.sv
// rr_select: combinational one-hot round-robin picker over a request vector and pointer
//   req_i  requests, bit i-1 = index i
//   ptr_i  last winner index; the search starts just above it
//   gnt_o  one-hot winner (0 when nothing requests)
//   idx_o  winner index (0 when nothing requests)
module rr_select
    import bus_arb_pkg::*;
#(
    parameter int NumMasters = 3
) (
    input  logic [NumMasters-2:0] req_i,
    input  logic [OwnerWidth-1:0] ptr_i,
    output logic [NumMasters-2:0] gnt_o,
    output logic [OwnerWidth-1:0] idx_o
);
    localparam int W = NumMasters - 1;

    always_comb begin
        idx_o = rr_next(7'(req_i), ptr_i, NumMasters);
        gnt_o = (idx_o == '0) ? '0 : W'(1) << (idx_o - 1'b1);
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: shares the CPU peripheral bus between the CPU (master 0) and auxiliary masters
//   clk_i, reset_ni               clock, asynchronous active-low reset
//   cpu_address_i/data_i/we_i     CPU bus request; cpu_rdy_o low stalls the CPU
//   m_req_i/address_i/data_i/we_i auxiliary masters, master i at slice i-1
//   m_gnt_o, m_timeout_o          one-hot grant, one-cycle forced-revoke pulse
//   bus_address_o/data_o/we_o     muxed bus to the address decoders
//   owner_o                       current owner index (0 = CPU)
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NumMasters    = 3,
    parameter int MaxHoldCycles = 4096,
    parameter int address_width = 16,
    parameter int data_width    = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic [address_width-1:0]               cpu_address_i,
    input  logic [data_width-1:0]                  cpu_data_i,
    input  logic                                   cpu_we_i,
    output logic                                   cpu_rdy_o,
    input  logic [NumMasters-2:0]                  m_req_i,
    input  logic [(NumMasters-1)*address_width-1:0] m_address_i,
    input  logic [(NumMasters-1)*data_width-1:0]   m_data_i,
    input  logic [NumMasters-2:0]                  m_we_i,
    output logic [NumMasters-2:0]                  m_gnt_o,
    output logic [NumMasters-2:0]                  m_timeout_o,
    output logic [address_width-1:0]               bus_address_o,
    output logic [data_width-1:0]                  bus_data_o,
    output logic                                   bus_we_o,
    output logic [OwnerWidth-1:0]                  owner_o
);
    localparam int M  = NumMasters - 1;
    localparam int CW = $clog2(MaxHoldCycles);
    localparam logic [CW-1:0] HoldLast = CW'(MaxHoldCycles - 1);

    arb_state_e            state_q;
    logic                  rdy_q;
    logic [M-1:0]          gnt_q, own_q, to_q, lock_q, lock_d;
    logic [M-1:0]          elig, win_oh;
    logic [OwnerWidth-1:0] owner_q, ptr_q, win_idx;
    logic [CW-1:0]         cnt_q;
    logic                  owner_req, hold_expire, start_grant;

    assign elig        = m_req_i & ~lock_q;
    assign owner_req   = |(m_req_i & own_q);
    // A release on the expiry edge wins over the timeout.
    assign hold_expire = state_q == GRANT && owner_req && cnt_q == HoldLast;
    assign lock_d      = (lock_q & m_req_i) | (hold_expire ? own_q : '0);
    // The CPU only hands over on a read cycle so it never loses the bus mid-write.
    assign start_grant = |elig && ((state_q == DRAIN && !cpu_we_i) || state_q == TURN);

    rr_select #(.NumMasters(NumMasters)) u_rr (
        .req_i(elig),
        .ptr_i(ptr_q),
        .gnt_o(win_oh),
        .idx_o(win_idx)
    );

    // own_q stays valid through TURN so the bus keeps the last owner's address/data.
    always_comb begin
        bus_address_o = cpu_address_i;
        bus_data_o    = cpu_data_i;
        bus_we_o      = cpu_we_i;
        if (state_q == GRANT || state_q == TURN) begin
            bus_we_o = state_q == GRANT && |(m_we_i & own_q);
            for (int i = 0; i < M; i++) begin
                if (own_q[i]) begin
                    bus_address_o = m_address_i[i*address_width +: address_width];
                    bus_data_o    = m_data_i[i*data_width +: data_width];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            gnt_q   <= '0;
            own_q   <= '0;
            to_q    <= '0;
            owner_q <= '0;
            ptr_q   <= OwnerWidth'(M);
            cnt_q   <= '0;
            lock_q  <= '0;
        end else begin
            lock_q <= lock_d;
            to_q   <= hold_expire ? own_q : '0;
            case (state_q)
                IDLE: if (|elig) begin
                    state_q <= DRAIN;
                    rdy_q   <= 1'b0;
                end
                DRAIN: if (~|elig) begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
                GRANT: if (!owner_req || hold_expire) begin
                    state_q <= TURN;
                    gnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                TURN: begin
                    cnt_q <= '0;
                    if (~|elig) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                        owner_q <= '0;
                    end
                end
            endcase
            if (start_grant) begin
                state_q <= GRANT;
                gnt_q   <= win_oh;
                own_q   <= win_oh;
                owner_q <= win_idx;
                ptr_q   <= win_idx;
                cnt_q   <= '0;
            end
        end
    end

    assign cpu_rdy_o   = rdy_q;
    assign m_gnt_o     = gnt_q;
    assign m_timeout_o = to_q;
    assign owner_o     = owner_q;

endmodule
